// File: rtl/generic_stream_fifo_pkg.sv
// Shared constants and payload type for the generic stream FIFO and the code that instantiates it.
package stream_fifo_pkg;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH + 1);

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
  } payload_t;

  // Occupancy counter width: must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/generic_stream_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port, no reset.
module generic_stream_fifo_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/generic_stream_fifo.sv
// Valid/ready stream FIFO with arbitrary depth, registered occupancy and optional empty-bypass.
module generic_stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int AF_LEVEL     = 3,
  parameter int FLOW_THROUGH = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [WIDTH-1:0]           i_push_data,
  output logic                       o_pop_valid,
  input  logic                       i_pop_ready,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int            CW       = cnt_width(DEPTH);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             bypass_mode, push, pop, bypass_xfer, wr_en, rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // Ready depends only on registered state so it never forms a path from i_pop_ready.
  assign o_push_ready = (count_q != FULL_CNT);
  assign bypass_mode  = (FLOW_THROUGH != 0) && (count_q == '0);
  assign o_pop_valid  = bypass_mode ? i_push_valid : (count_q != '0);
  assign push         = i_push_valid && o_push_ready;
  assign pop          = o_pop_valid && i_pop_ready;
  assign bypass_xfer  = bypass_mode && push && pop;
  assign wr_en        = push && !bypass_xfer;
  assign rd_en        = pop && !bypass_mode;

  always_comb begin
    o_pop_data = '0;
    if (bypass_mode) begin
      if (i_push_valid) o_pop_data = i_push_data;
    end else if (count_q != '0) begin
      o_pop_data = mem_rdata;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (i_clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) wptr_d = ptr_inc(wptr_q);
      if (rd_en) rptr_d = ptr_inc(rptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign o_count       = count_q;
  assign o_almost_full = (count_q >= AF_CNT);

  generic_stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (wr_en && !i_clear && !i_rst),
    .waddr_i (wptr_q),
    .wdata_i (i_push_data),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_generic_stream_fifo.sv
// Directed scoreboard bench for three FIFO configurations: depth 4, depth 5, and depth 4 flow-through.
module tb_generic_stream_fifo;
  import stream_fifo_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr [N];
  logic       pv  [N];
  logic       pr  [N];
  logic       prdy[N];
  logic       pval[N];
  logic       af  [N];
  logic [7:0] pd   [N];
  logic [7:0] pdata[N];
  logic [2:0] cnt  [N];

  int dep[N] = '{4, 5, 4};
  int afl[N] = '{3, 4, 2};
  int ft [N] = '{0, 0, 1};

  int         mcnt[N];
  logic [7:0] sb[$];
  int         n_chk, n_fail;

  always #5 clk = ~clk;

  generic_stream_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .FLOW_THROUGH(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr[0]),
    .i_push_valid(pv[0]), .o_push_ready(prdy[0]), .i_push_data(pd[0]),
    .o_pop_valid(pval[0]), .i_pop_ready(pr[0]), .o_pop_data(pdata[0]),
    .o_count(cnt[0]), .o_almost_full(af[0]));

  generic_stream_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .FLOW_THROUGH(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr[1]),
    .i_push_valid(pv[1]), .o_push_ready(prdy[1]), .i_push_data(pd[1]),
    .o_pop_valid(pval[1]), .i_pop_ready(pr[1]), .o_pop_data(pdata[1]),
    .o_count(cnt[1]), .o_almost_full(af[1]));

  generic_stream_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(2), .FLOW_THROUGH(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr[2]),
    .i_push_valid(pv[2]), .o_push_ready(prdy[2]), .i_push_data(pd[2]),
    .o_pop_valid(pval[2]), .i_pop_ready(pr[2]), .o_pop_data(pdata[2]),
    .o_count(cnt[2]), .o_almost_full(af[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One clock of stimulus on instance k; outputs are checked at the falling edge.
  task automatic cyc(input int k, input bit v, input logic [7:0] d, input bit r, input bit c);
    bit bp, ev, dopush, dopop;
    pv[k] = v; pd[k] = d; pr[k] = r; clr[k] = c;
    @(negedge clk);
    bp = (ft[k] != 0) && (mcnt[k] == 0);
    ev = bp ? v : (mcnt[k] != 0);
    chk("push_ready", 32'(prdy[k]), 32'(mcnt[k] != dep[k]));
    chk("pop_valid", 32'(pval[k]), 32'(ev));
    chk("count", 32'(cnt[k]), mcnt[k]);
    chk("almost_full", 32'(af[k]), 32'(mcnt[k] >= afl[k]));
    if (!ev)     chk("pop_data_idle", 32'(pdata[k]), 0);
    else if (bp) chk("bypass_data", 32'(pdata[k]), 32'(d));
    else         chk("pop_data", 32'(pdata[k]), 32'(sb[0]));
    dopush = v && (mcnt[k] != dep[k]);
    dopop  = ev && r;
    if (c) begin
      mcnt[k] = 0;
      sb.delete();
    end else if (!(bp && dopush && dopop)) begin
      if (dopush) sb.push_back(d);
      if (dopop) void'(sb.pop_front());
      mcnt[k] = mcnt[k] + int'(dopush) - int'(dopop);
    end
    @(posedge clk); #1;
    pv[k] = 1'b0; pd[k] = '0; pr[k] = 1'b0; clr[k] = 1'b0;
  endtask

  // Reset edge, optionally with a concurrent push on instance 0 that must be discarded.
  task automatic do_reset(input bit push0);
    rst = 1'b1;
    pv[0] = push0; pd[0] = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0;
    pv[0] = 1'b0; pd[0] = '0;
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    sb.delete();
  endtask

  initial begin
    payload_t pl;
    int pushed;
    bit acc;
    n_chk = 0; n_fail = 0;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      clr[k] = 1'b0; pv[k] = 1'b0; pr[k] = 1'b0; pd[k] = '0; mcnt[k] = 0;
    end

    // Reset state on every instance
    do_reset(1'b0);
    for (int k = 0; k < N; k++) cyc(k, 0, 8'h00, 0, 0);

    // Fill, overfill attempt, drain, then pop on empty
    pl.data = 2'h1; cyc(0, 1, 8'(pl.data), 0, 0);
    cyc(0, 1, 8'h02, 0, 0);
    cyc(0, 1, 8'h03, 0, 0);
    cyc(0, 1, 8'h00, 0, 0);
    cyc(0, 1, 8'hAA, 0, 0);
    chk("full_count", 32'(cnt[0]), 4);
    chk("full_af", 32'(af[0]), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);

    // Steady-state push+pop at count 3; 13 pushes wrap the depth-4 pointers three times
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'(8'h30 + i), 1, 0);
    chk("steady_count", 32'(cnt[0]), 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("steady_drained", 32'(cnt[0]), 0);

    // Depth 5: 12 pushes against a 50% pop duty cycle
    do_reset(1'b0);
    pushed = 0;
    for (int i = 0; i < 40 && pushed < 12; i++) begin
      acc = (mcnt[1] != 5);
      cyc(1, 1, 8'(8'h40 + pushed), bit'(i % 2), 0);
      if (acc) pushed++;
      chk("d5_max", 32'(cnt[1] <= 3'd5), 1);
    end
    for (int i = 0; i < 20 && mcnt[1] != 0; i++) cyc(1, 0, 8'h00, 1, 0);
    chk("d5_drained", 32'(cnt[1]), 0);

    // Flow-through: bypass transfer, then stored traffic
    do_reset(1'b0);
    cyc(2, 1, 8'h02, 1, 0);
    cyc(2, 0, 8'h00, 0, 0);
    cyc(2, 1, 8'h05, 0, 0);
    cyc(2, 1, 8'h06, 1, 0);
    cyc(2, 0, 8'h00, 1, 0);
    cyc(2, 0, 8'h00, 0, 0);

    // Clear with concurrent push, then reset with concurrent push
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h50 + i), 0, 0);
    cyc(0, 1, 8'h01, 0, 1);
    cyc(0, 0, 8'h00, 0, 0);
    chk("clear_count", 32'(cnt[0]), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h60 + i), 0, 0);
    do_reset(1'b1);
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_pop_valid", 32'(pval[0]), 0);
    cyc(0, 0, 8'h00, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
